// File: rtl/ss_pkg.sv
// Shared definitions for the seven-segment display path: BCD digit types
// and constants used by the converter and the display controller.
package ss_pkg;

  localparam int DIGIT_W        = 4;
  localparam int NUM_DIGITS_DEF = 4;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  // Same 4x4 packed digit view the seven-segment controller uses
  typedef bcd_digit_t [NUM_DIGITS_DEF-1:0] bcd_word_t;

  localparam bcd_digit_t BCD_NINE = 4'h9;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before
// the next left shift so the shift carries correctly into the next digit.
module bcd_digit_adjust (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);
  import ss_pkg::*;

  assign digit_o = (digit_i >= bcd_digit_t'(5)) ? digit_i + bcd_digit_t'(3) : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one bit per clock,
// feeding the seven-segment controller; out-of-range values saturate to all nines.
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH  = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    valid_i,
  input  logic [BIN_WIDTH-1:0]    bin_i,
  output logic                    ready_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o,
  output logic                    bcd_valid_o,
  output logic                    overflow_o
);
  import ss_pkg::*;

  localparam int BCD_W = DIGIT_W * NUM_DIGITS;
  localparam int SR_W  = BCD_W + BIN_WIDTH;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  // Wide enough for both bin_i and 10**NUM_DIGITS-1, plus one spare bit
  localparam int CMP_W = ((BIN_WIDTH > BCD_W) ? BIN_WIDTH : BCD_W) + 1;

  function automatic logic [CMP_W-1:0] max_value();
    logic [CMP_W-1:0] v;
    v = CMP_W'(1);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      v = v * CMP_W'(10);
    end
    return v - CMP_W'(1);
  endfunction

  localparam logic [CMP_W-1:0] MAX_VAL = max_value();

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  sr_adj;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  assign ready_o = (state == IDLE);

  // Correct every BCD digit in parallel; the binary field passes through
  assign sr_adj[BIN_WIDTH-1:0] = sr[BIN_WIDTH-1:0];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (sr[BIN_WIDTH + DIGIT_W*g +: DIGIT_W]),
      .digit_o (sr_adj[BIN_WIDTH + DIGIT_W*g +: DIGIT_W])
    );
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= IDLE;
      sr          <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      bcd_o       <= '0;
      bcd_valid_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      bcd_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            sr    <= {{BCD_W{1'b0}}, bin_i};
            cnt   <= CNT_W'(BIN_WIDTH);
            ovf   <= (CMP_W'(bin_i) > MAX_VAL);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sr  <= sr_adj << 1;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          bcd_o       <= ovf ? {NUM_DIGITS{BCD_NINE}} : sr[SR_W-1 -: BCD_W];
          overflow_o  <= ovf;
          bcd_valid_o <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential shift-and-add-3 (double-dabble) converter that turns an unsigned binary value into packed BCD digits for the seven-segment display path. It sits directly upstream of the seven-segment controller, and its bcd_o drives the controller's 16-bit digit input. Conversion is iterative, one bit per clock, with a valid/ready input handshake and a one-cycle result strobe. Out-of-range inputs saturate to all nines and set an overflow flag.

Parameters:
BIN_WIDTH, 14, width of binary input; must be >= 4.
NUM_DIGITS, 4, number of BCD digits produced; bcd_o width = 4*NUM_DIGITS.

Ports:
clk_i  input  1  single clock; all state updates on rising edge.
reset_i  input  1  synchronous, active-high reset.
valid_i  input  1  binary value on bin_i is offered this cycle.
bin_i  input  BIN_WIDTH  unsigned binary value to convert.
ready_o  output  1  block idle and will accept valid_i this cycle.
bcd_o  output  4*NUM_DIGITS  held result; digit 0 (least significant) in bits [3:0], digit n in [4n+3:4n].
bcd_valid_o  output  1  one-cycle strobe; bcd_o/overflow_o updated this cycle.
overflow_o  output  1  last result saturated; held with bcd_o.

Behaviour:
- Interface timing: one clock (clk_i); reset_i is synchronous, active-high.
- Reset values: state IDLE, so ready_o=1. Also bcd_o=0, bcd_valid_o=0, overflow_o=0, shift register=0, bit counter=0.
- ready_o is combinational: 1 exactly when state==IDLE.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on an edge with valid_i=1, do all of the following, then go to SHIFT:
  - load shift register {BCD field=0, BIN field=bin_i};
  - set counter=BIN_WIDTH;
  - latch ovf = (bin_i > 10**NUM_DIGITS - 1); this comparison is width-safe, and ovf is constant 0 if 2**BIN_WIDTH <= 10**NUM_DIGITS.
- SHIFT, per edge:
  - every BCD digit >= 5 gets +3 (4-bit, no carry out);
  - the whole register then shifts left 1;
  - counter decrements;
  - when counter==1 on that edge, next state is DONE.
  - Exactly BIN_WIDTH shift edges occur.
- DONE, one edge:
  - bcd_o <= ovf ? all digits 4'h9 : BCD field;
  - overflow_o <= ovf; bcd_valid_o <= 1;
  - state <= IDLE.
- bcd_valid_o is high for exactly the cycle following the DONE edge and is 0 in every other cycle.
- Latency: accept on edge k gives bcd_o/bcd_valid_o visible after edge k+BIN_WIDTH+1 (15 for the default).
- Throughput: ready_o=0 for BIN_WIDTH+1 cycles after acceptance. The next acceptance can occur on the edge that ends the bcd_valid_o cycle.
- valid_i while ready_o=0 is ignored: no queuing, no effect on the conversion in flight.
- bcd_o and overflow_o hold their value between conversions. They change only on the DONE edge or on reset.
- Reset mid-conversion: the conversion is aborted; no bcd_valid_o; outputs return to reset values on the next edge.
- reset_i and valid_i both high on the same edge: reset wins, the input is not accepted.
- Shift-register width: 4*NUM_DIGITS + BIN_WIDTH. Only the BCD field is observable.

Decomposition:
- Shared package ss_pkg:
  - DIGIT_W=4;
  - typedef bcd_digit_t (logic [3:0]);
  - typedef bcd_word_t (packed [NUM_DIGITS-1:0] of bcd_digit_t, default 4 digits). This matches the controller's 4x4 packed digit view.
  - localparam BCD_NINE=4'h9.
  - FSM enum state_t {IDLE, SHIFT, DONE} is local to the module.
- One combinational sub-module, bcd_digit_adjust: 4-bit in, 4-bit out, +3 when input >= 5. Instantiated NUM_DIGITS times in a generate loop.

Test Plan:
- Reset, then idle -> ready_o=1, bcd_o=16'h0000, bcd_valid_o=0, overflow_o=0.
- valid_i=1 with bin_i=0 -> after 15 edges bcd_o=16'h0000, one-cycle bcd_valid_o, overflow_o=0.
- bin_i=1234, then 9999, then 10 (valid_i held high) -> bcd_o=16'h1234, 16'h9999, 16'h0010 in turn, strobes exactly 16 cycles apart, ready_o low 15 cycles each.
- bin_i=10000, then 16383 -> bcd_o=16'h9999 with overflow_o=1 for both; next input 42 -> bcd_o=16'h0042, overflow_o=0.
- Accept 5678, pulse valid_i with bin_i=1111 at cycles 3 and 10 of the conversion -> result 16'h5678; 1111 never converted.
- Accept 4321, assert reset_i at cycle 7 -> no bcd_valid_o, bcd_o=0, ready_o=1 next cycle. A following bin_i=8765 converts correctly to 16'h8765.
